result_writeback: RTL and testbench
===================================

# result_writeback

Downstream stage of the adder tree. Accumulates `PASSES` consecutive signed partial sums per output element and saturates each sum to `DATA_WIDTH`. Packs pairs of finished elements into 32-bit words and writes them through output memory port b. Raises `done` after the last word of a run is written. Runs in the PL clock domain only.

## Interface
- `DATA_WIDTH`, 16: width of the partial sum and of the stored element (signed two's complement).
- `ADDR_WIDTH`, 11: output memory word address width (32-bit words).
- `NUM_RESULTS`, 4096: elements per run. Must be even and ≤ 2·2^ADDR_WIDTH.
- `PASSES`, 1: partial sums accumulated per element, 1..16.
- `clk` in 1: PL clock. One clock only. Reset is asynchronous and active-low.
- `rst_n` in 1: async active-low reset.
- `start` in 1: single-cycle pulse that begins a run.
- `in_valid` in 1: `in_data` carries a partial sum this cycle.
- `in_data` in DATA_WIDTH: adder tree result.
- `en_out` out 1: output memory port-b enable.
- `we_out` out 4: byte write enables.
- `addr_out` out ADDR_WIDTH: word address.
- `din_out` out 32: write data. Bits [15:0] hold the even element, bits [31:16] the odd element.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at end of run.
- `sat_flag` out 1: sticky; set if any element of the current run saturated.
- `err_flag` out 1: sticky; set if `in_valid` arrives while not in RUN.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: processes input beats.
  - FLUSH: issues the last write.
  - DONE: pulses `done`.
- Transitions:
  - IDLE→RUN on `start`. This clears the counters, `sat_flag` and `err_flag`.
  - RUN→FLUSH when the beat completing element `NUM_RESULTS-1` is accepted.
  - FLUSH→DONE after one cycle.
  - DONE→IDLE after one cycle.
- Counters:
  - `pass_cnt`, 0..PASSES-1.
  - `elem_cnt`, 0..NUM_RESULTS-1.
  - `word_addr`, starts at 0 and increments after each write.
- Accumulator:
  - Width DATA_WIDTH+5.
  - Each `in_data` is sign-extended. It loads the accumulator on `pass_cnt==0` and adds to it otherwise.
- Element completion (beat with `pass_cnt==PASSES-1`): the sum is clamped to [-2^(DW-1), 2^(DW-1)-1]. Clamping sets `sat_flag`.
- Packing:
  - Even `elem_cnt`: the clamped value goes to the low-half holding register.
  - Odd `elem_cnt`: a write is issued with `din_out={odd,held_even}`, `we_out=4'hF`, `en_out=1`.
- `in_valid` when not in RUN: the beat is dropped and `err_flag` is set.
- `start` outside IDLE is ignored.
- `in_valid` with `in_valid` low mid-element: accumulator and counters hold; gaps are allowed.
- Reset mid-run: returns to IDLE immediately. Partial words are discarded and no write is issued.

## Timing
- Reset values:
  - `en_out=0`, `we_out=0`, `addr_out=0`, `din_out=0`.
  - `busy=0`, `done=0`, `sat_flag=0`, `err_flag=0`.
  - State is IDLE.
- All outputs are registered.
- Write latency: an odd element completing at cycle t gives `en_out`/`we_out`/`addr_out`/`din_out` valid during cycle t+1 only. At most one write per cycle.
- Final beat at cycle t:
  - The last write occurs at t+1, during FLUSH.
  - `done` is high at t+2, during DONE.
  - `busy` is low from t+3.
- `busy` rises the cycle after `start` and is high throughout RUN, FLUSH and DONE.
- A `start` in the same cycle that `done` is high is ignored.
- Full-rate input (one beat per cycle) is sustained with no stalls. There is no backpressure.
- `addr_out` of the k-th write equals k-1. It wraps at 2^ADDR_WIDTH and cannot reach the wrap when the parameters are legal.

## Structure
- Shared package `matmul_pkg` holds:
  - `DATA_WIDTH`, `ARRAY_SIZE`, `OUT_ADDR_WIDTH` constants.
  - The `wb_state_t` enum (IDLE, RUN, FLUSH, DONE).
  - The saturation min/max constants.
- Sub-module `sat_accumulator` holds the load/add accumulator, the clamp, and the saturate indication. It is purely datapath, with clock and reset.
- The top-level instantiation sits between `adder_tree` and `output_memory` port b.

## Test plan
- PASSES=1, NUM_RESULTS=4, inputs 1,2,3,4 back-to-back → writes `addr 0 din 0x0002_0001`, `addr 1 din 0x0004_0003`; `done` 2 cycles after beat 4; `sat_flag=0`.
- PASSES=4, inputs 0x7000 ×4 for element 0, then -1 ×4 → element 0 clamps to 0x7FFF and element 1 is 0xFFFC; single write `0xFFFC_7FFF`; `sat_flag=1`.
- PASSES=2, random `in_valid` gaps over 64 elements → 32 writes, sequential addresses, data matching the reference model; no write while `in_valid` is idle.
- `in_valid` high in IDLE, then `start`, then a second `start` mid-run → `err_flag` set pre-start and cleared by `start`; the second `start` is ignored and the run completes normally.
- `rst_n` low after element 5 of 8 → all outputs 0 next edge; no further writes; a fresh `start` produces writes from `addr 0`.
- NUM_RESULTS=4096, full-rate input → 2048 writes, last at `addr 0x7FF`, `done` exactly once.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants and types for the matmul result path.
// Packing into 32-bit words assumes DATA_WIDTH == 16.
package matmul_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int ARRAY_SIZE     = 16;
    localparam int OUT_ADDR_WIDTH = 11;
    localparam int ACC_GUARD      = 5;

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n < 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/result_writeback_if.sv
// Handshake and port-b bundle between the adder tree, result_writeback and output memory.
interface result_writeback_if #(
    parameter int DATA_WIDTH = matmul_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = matmul_pkg::OUT_ADDR_WIDTH
);

    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  en_out;
    logic [3:0]            we_out;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic [31:0]           din_out;
    logic                  busy;
    logic                  done;
    logic                  sat_flag;
    logic                  err_flag;

    modport slave (
        input  start, in_valid, in_data,
        output en_out, we_out, addr_out, din_out, busy, done, sat_flag, err_flag
    );

    modport master (
        output start, in_valid, in_data,
        input  en_out, we_out, addr_out, din_out, busy, done, sat_flag, err_flag
    );

endinterface

// File: rtl/result_writeback_sat_accumulator.sv
// Load/add accumulator with guard bits; clamps the running sum (including the
// current beat) to the signed DATA_WIDTH range and flags when clamping happens.
module sat_accumulator #(
    parameter int DATA_WIDTH = matmul_pkg::DATA_WIDTH,
    parameter int GUARD      = matmul_pkg::ACC_GUARD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  valid,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] sum_sat,
    output logic                  sat
);

    localparam int AW = DATA_WIDTH + GUARD;
    localparam logic signed [AW-1:0] MAX_V = {{(GUARD + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(GUARD + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] next_acc;

    // Sum with the current beat folded in, so completion needs no extra cycle.
    always_comb begin
        ext = {{GUARD{in_data[DATA_WIDTH-1]}}, in_data};
        if (load) begin
            next_acc = ext;
        end else begin
            next_acc = acc + ext;
        end
    end

    // Clamp to the representable element range.
    always_comb begin
        sum_sat = next_acc[DATA_WIDTH-1:0];
        sat     = 1'b0;
        if (next_acc > MAX_V) begin
            sum_sat = MAX_V[DATA_WIDTH-1:0];
            sat     = 1'b1;
        end else if (next_acc < MIN_V) begin
            sum_sat = MIN_V[DATA_WIDTH-1:0];
            sat     = 1'b1;
        end else begin
            sum_sat = next_acc[DATA_WIDTH-1:0];
            sat     = 1'b0;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= {AW{1'b0}};
        end else if (clear) begin
            acc <= {AW{1'b0}};
        end else if (valid) begin
            acc <= next_acc;
        end
    end

endmodule

// File: rtl/result_writeback.sv
// Accumulates PASSES partial sums per element, saturates, packs element pairs
// into 32-bit words and writes them to output memory port b; pulses done at end of run.
module result_writeback #(
    parameter int DATA_WIDTH  = matmul_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = matmul_pkg::OUT_ADDR_WIDTH,
    parameter int NUM_RESULTS = 4096,
    parameter int PASSES      = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    result_writeback_if.slave  bus
);

    import matmul_pkg::*;

    localparam int PW = cnt_width(PASSES);
    localparam int EW = cnt_width(NUM_RESULTS);
    localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);
    localparam logic [EW-1:0] ELEM_LAST = EW'(NUM_RESULTS - 1);

    wb_state_t             state;
    wb_state_t             next_state;
    logic [PW-1:0]         pass_cnt;
    logic [EW-1:0]         elem_cnt;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0] held_even;
    logic [DATA_WIDTH-1:0] sum_sat;
    logic                  sat;
    logic                  accept;
    logic                  elem_done;
    logic                  last_elem;
    logic                  run_start;
    logic                  first_pass;

    sat_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .GUARD      (ACC_GUARD)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (run_start),
        .valid   (accept),
        .load    (first_pass),
        .in_data (bus.in_data),
        .sum_sat (sum_sat),
        .sat     (sat)
    );

    // Beat acceptance and element/run completion decode.
    always_comb begin
        run_start  = (state == IDLE) && bus.start;
        accept     = (state == RUN) && bus.in_valid;
        first_pass = (pass_cnt == {PW{1'b0}});
        elem_done  = accept && (pass_cnt == PASS_LAST);
        last_elem  = elem_done && (elem_cnt == ELEM_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (last_elem) begin
                    next_state = FLUSH;
                end else begin
                    next_state = RUN;
                end
            end
            FLUSH:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pass/element counters, write address and even-element holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt  <= {PW{1'b0}};
            elem_cnt  <= {EW{1'b0}};
            word_addr <= {ADDR_WIDTH{1'b0}};
            held_even <= {DATA_WIDTH{1'b0}};
        end else if (run_start) begin
            pass_cnt  <= {PW{1'b0}};
            elem_cnt  <= {EW{1'b0}};
            word_addr <= {ADDR_WIDTH{1'b0}};
        end else if (elem_done) begin
            pass_cnt <= {PW{1'b0}};
            elem_cnt <= last_elem ? {EW{1'b0}} : elem_cnt + EW'(1);
            if (elem_cnt[0]) begin
                word_addr <= word_addr + ADDR_WIDTH'(1);
            end else begin
                held_even <= sum_sat;
            end
        end else if (accept) begin
            pass_cnt <= pass_cnt + PW'(1);
        end
    end

    // Registered port-b write and status outputs; the write lands one cycle after the odd element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.en_out   <= 1'b0;
            bus.we_out   <= 4'h0;
            bus.addr_out <= {ADDR_WIDTH{1'b0}};
            bus.din_out  <= 32'h0000_0000;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.sat_flag <= 1'b0;
            bus.err_flag <= 1'b0;
        end else begin
            if (elem_done && elem_cnt[0]) begin
                bus.en_out   <= 1'b1;
                bus.we_out   <= 4'hF;
                bus.addr_out <= word_addr;
                bus.din_out  <= 32'({sum_sat, held_even});
            end else begin
                bus.en_out <= 1'b0;
                bus.we_out <= 4'h0;
            end
            bus.busy <= (next_state != IDLE);
            bus.done <= (next_state == DONE);
            if (run_start) begin
                bus.sat_flag <= 1'b0;
            end else if (elem_done && sat) begin
                bus.sat_flag <= 1'b1;
            end
            // A stray beat outside RUN wins over the clear from a simultaneous start.
            if (bus.in_valid && (state != RUN)) begin
                bus.err_flag <= 1'b1;
            end else if (run_start) begin
                bus.err_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: several parameterisations side by side,
// writes captured by monitors and compared against an element-level reference model.
module tb_result_writeback;

    import matmul_pkg::*;

    typedef struct {
        int          c;
        logic [10:0] a;
        logic [31:0] d;
        logic [3:0]  w;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   n_pass = 0;
    int   n_chk  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    result_writeback_if ia ();
    result_writeback_if ib ();
    result_writeback_if ic ();
    result_writeback_if id ();
    result_writeback_if ie ();

    result_writeback #(.NUM_RESULTS(4),    .PASSES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    result_writeback #(.NUM_RESULTS(2),    .PASSES(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    result_writeback #(.NUM_RESULTS(64),   .PASSES(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));
    result_writeback #(.NUM_RESULTS(4096), .PASSES(1)) dut_d (.clk(clk), .rst_n(rst_n), .bus(id));
    result_writeback #(.NUM_RESULTS(8),    .PASSES(1)) dut_e (.clk(clk), .rst_n(rst_n), .bus(ie));

    wr_t qa[$], qb[$], qc[$], qd[$], qe[$];
    int  dna[$], dnb[$], dnc[$], dnd[$], dne[$];

    always @(negedge clk) begin
        if (ia.en_out) qa.push_back(wr_t'{cyc, ia.addr_out, ia.din_out, ia.we_out});
        if (ia.done) dna.push_back(cyc);
    end
    always @(negedge clk) begin
        if (ib.en_out) qb.push_back(wr_t'{cyc, ib.addr_out, ib.din_out, ib.we_out});
        if (ib.done) dnb.push_back(cyc);
    end
    always @(negedge clk) begin
        if (ic.en_out) qc.push_back(wr_t'{cyc, ic.addr_out, ic.din_out, ic.we_out});
        if (ic.done) dnc.push_back(cyc);
    end
    always @(negedge clk) begin
        if (id.en_out) qd.push_back(wr_t'{cyc, id.addr_out, id.din_out, id.we_out});
        if (id.done) dnd.push_back(cyc);
    end
    always @(negedge clk) begin
        if (ie.en_out) qe.push_back(wr_t'{cyc, ie.addr_out, ie.din_out, ie.we_out});
        if (ie.done) dne.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic test_reset();
        n_chk++; if ({ia.en_out, ia.we_out, ia.addr_out, ia.din_out, ia.busy, ia.done, ia.sat_flag, ia.err_flag} !== 52'd0)
            $display("FAIL reset_a outputs=%h want 0", {ia.en_out, ia.we_out, ia.addr_out, ia.din_out, ia.busy, ia.done, ia.sat_flag, ia.err_flag}); else n_pass++;
        n_chk++; if ({ib.en_out, ib.we_out, ib.addr_out, ib.din_out, ib.busy, ib.done, ib.sat_flag, ib.err_flag} !== 52'd0)
            $display("FAIL reset_b outputs=%h want 0", {ib.en_out, ib.we_out, ib.addr_out, ib.din_out, ib.busy, ib.done, ib.sat_flag, ib.err_flag}); else n_pass++;
        n_chk++; if ({id.en_out, id.we_out, id.addr_out, id.din_out, id.busy, id.done, id.sat_flag, id.err_flag} !== 52'd0)
            $display("FAIL reset_d outputs=%h want 0", {id.en_out, id.we_out, id.addr_out, id.din_out, id.busy, id.done, id.sat_flag, id.err_flag}); else n_pass++;
    endtask

    task automatic test_basic();
        int t;
        qa.delete(); dna.delete();
        ia.start = 1'b1; step(1); ia.start = 1'b0;
        n_chk++; if (ia.busy !== 1'b1) $display("FAIL basic_busy_rise got %b want 1", ia.busy); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            ia.in_valid = 1'b1; ia.in_data = 16'(i);
            t = cyc;
            step(1);
        end
        ia.in_valid = 1'b0;
        step(1);
        // done is visible now; a start here must be ignored
        ia.start = 1'b1; step(1); ia.start = 1'b0;
        n_chk++; if (ia.busy !== 1'b0) $display("FAIL basic_busy_fall got %b want 0 at t+3", ia.busy); else n_pass++;
        step(3);
        n_chk++; if (ia.busy !== 1'b0) $display("FAIL basic_start_on_done got busy=%b want 0", ia.busy); else n_pass++;
        n_chk++; if (qa.size() != 2) $display("FAIL basic_nwrites got %0d want 2", qa.size()); else n_pass++;
        if (qa.size() >= 2) begin
            n_chk++; if (qa[0].a !== 11'd0 || qa[0].d !== 32'h0002_0001 || qa[0].w !== 4'hF || qa[0].c != t - 1)
                $display("FAIL basic_w0 got a=%0h d=%h we=%h c=%0d want a=0 d=00020001 we=f c=%0d", qa[0].a, qa[0].d, qa[0].w, qa[0].c, t - 1); else n_pass++;
            n_chk++; if (qa[1].a !== 11'd1 || qa[1].d !== 32'h0004_0003 || qa[1].w !== 4'hF || qa[1].c != t + 1)
                $display("FAIL basic_w1 got a=%0h d=%h we=%h c=%0d want a=1 d=00040003 we=f c=%0d", qa[1].a, qa[1].d, qa[1].w, qa[1].c, t + 1); else n_pass++;
        end
        n_chk++; if (dna.size() != 1 || dna[0] != t + 2)
            $display("FAIL basic_done got n=%0d first=%0d want n=1 at %0d", dna.size(), (dna.size() > 0) ? dna[0] : -1, t + 2); else n_pass++;
        n_chk++; if (ia.sat_flag !== 1'b0) $display("FAIL basic_sat got %b want 0", ia.sat_flag); else n_pass++;
    endtask

    task automatic test_flags();
        int t;
        qa.delete(); dna.delete();
        ia.in_valid = 1'b1; ia.in_data = 16'h1234; step(1); ia.in_valid = 1'b0;
        n_chk++; if (ia.err_flag !== 1'b1) $display("FAIL flags_err_idle got %b want 1", ia.err_flag); else n_pass++;
        ia.start = 1'b1; step(1); ia.start = 1'b0;
        n_chk++; if (ia.err_flag !== 1'b0 || ia.busy !== 1'b1)
            $display("FAIL flags_err_clear got err=%b busy=%b want err=0 busy=1", ia.err_flag, ia.busy); else n_pass++;
        ia.in_valid = 1'b1; ia.in_data = 16'd5; step(1);
        ia.in_data = 16'd6; step(1);
        ia.in_valid = 1'b0; ia.start = 1'b1; step(1); ia.start = 1'b0;
        ia.in_valid = 1'b1; ia.in_data = 16'd7; step(1);
        ia.in_data = 16'd8; t = cyc; step(1);
        ia.in_valid = 1'b0;
        step(4);
        n_chk++; if (qa.size() != 2) $display("FAIL flags_nwrites got %0d want 2", qa.size()); else n_pass++;
        if (qa.size() >= 2) begin
            n_chk++; if (qa[0].a !== 11'd0 || qa[0].d !== 32'h0006_0005 || qa[1].a !== 11'd1 || qa[1].d !== 32'h0008_0007)
                $display("FAIL flags_data got %0h:%h %0h:%h want 0:00060005 1:00080007", qa[0].a, qa[0].d, qa[1].a, qa[1].d); else n_pass++;
        end
        n_chk++; if (dna.size() != 1 || dna[0] != t + 2)
            $display("FAIL flags_done got n=%0d want 1 at %0d", dna.size(), t + 2); else n_pass++;
        n_chk++; if (ia.err_flag !== 1'b0) $display("FAIL flags_err_end got %b want 0", ia.err_flag); else n_pass++;
    endtask

    task automatic test_saturate();
        int t;
        int s0, s1;
        logic [31:0] exp_w;
        qb.delete(); dnb.delete();
        ib.start = 1'b1; step(1); ib.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ib.in_valid = 1'b1;
            ib.in_data  = (i < 4) ? 16'h7000 : 16'hFFFF;
            t = cyc;
            step(1);
        end
        ib.in_valid = 1'b0;
        step(4);
        s0 = clamp(4 * 28672);
        s1 = clamp(-4);
        exp_w = {16'(s1), 16'(s0)};
        n_chk++; if (qb.size() != 1) $display("FAIL sat_nwrites got %0d want 1", qb.size()); else n_pass++;
        if (qb.size() >= 1) begin
            n_chk++; if (qb[0].a !== 11'd0 || qb[0].d !== exp_w || qb[0].c != t + 1)
                $display("FAIL sat_word got a=%0h d=%h c=%0d want a=0 d=%h c=%0d", qb[0].a, qb[0].d, qb[0].c, exp_w, t + 1); else n_pass++;
        end
        n_chk++; if (ib.sat_flag !== 1'b1) $display("FAIL sat_flag got %b want 1", ib.sat_flag); else n_pass++;
        n_chk++; if (dnb.size() != 1 || dnb[0] != t + 2)
            $display("FAIL sat_done got n=%0d want 1 at %0d", dnb.size(), t + 2); else n_pass++;
    endtask

    task automatic test_gaps();
        int beats[$];
        int bcyc[$];
        logic [15:0] d;
        int sum, c, held, k;
        logic sat_exp;
        logic [31:0] exp_w;
        qc.delete(); dnc.delete();
        ic.start = 1'b1; step(1); ic.start = 1'b0;
        for (int g = 0; g < 2000 && beats.size() < 128; g++) begin
            if ($urandom_range(2, 0) == 0) begin
                ic.in_valid = 1'b0;
            end else begin
                d = 16'($urandom);
                ic.in_valid = 1'b1; ic.in_data = d;
                beats.push_back($signed(d));
                bcyc.push_back(cyc);
            end
            step(1);
        end
        ic.in_valid = 1'b0;
        step(5);
        n_chk++; if (qc.size() != 32) $display("FAIL gaps_nwrites got %0d want 32", qc.size()); else n_pass++;
        sat_exp = 1'b0; held = 0; k = 0;
        for (int e = 0; e < 64 && 2 * e + 1 < beats.size(); e++) begin
            sum = beats[2 * e] + beats[2 * e + 1];
            c = clamp(sum);
            if (c != sum) sat_exp = 1'b1;
            if (e % 2 == 0) begin
                held = c;
            end else begin
                exp_w = {16'(c), 16'(held)};
                if (k < qc.size()) begin
                    n_chk++; if (qc[k].a !== 11'(k) || qc[k].d !== exp_w || qc[k].w !== 4'hF || qc[k].c != bcyc[2 * e + 1] + 1)
                        $display("FAIL gaps_w%0d got a=%0h d=%h we=%h c=%0d want a=%0h d=%h we=f c=%0d", k, qc[k].a, qc[k].d, qc[k].w, qc[k].c, k, exp_w, bcyc[2 * e + 1] + 1); else n_pass++;
                end
                k++;
            end
        end
        n_chk++; if (ic.sat_flag !== sat_exp) $display("FAIL gaps_sat got %b want %b", ic.sat_flag, sat_exp); else n_pass++;
        n_chk++; if (dnc.size() != 1 || beats.size() != 128 || dnc[0] != bcyc[127] + 2)
            $display("FAIL gaps_done got n=%0d beats=%0d want n=1 beats=128", dnc.size(), beats.size()); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int beats[$];
        logic [15:0] d;
        int base;
        logic [31:0] exp_w;
        qe.delete(); dne.delete();
        ie.start = 1'b1; step(1); ie.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ie.in_valid = 1'b1; ie.in_data = 16'(10 + i); step(1);
        end
        ie.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_chk++; if ({ie.en_out, ie.we_out, ie.addr_out, ie.din_out, ie.busy, ie.done, ie.sat_flag, ie.err_flag} !== 52'd0)
            $display("FAIL rst_mid_outputs got %h want 0", {ie.en_out, ie.we_out, ie.addr_out, ie.din_out, ie.busy, ie.done, ie.sat_flag, ie.err_flag}); else n_pass++;
        step(1);
        rst_n = 1'b1;
        step(4);
        n_chk++; if (qe.size() != 2 || ie.busy !== 1'b0)
            $display("FAIL rst_mid_nowrite got writes=%0d busy=%b want 2 0", qe.size(), ie.busy); else n_pass++;
        base = qe.size();
        ie.start = 1'b1; step(1); ie.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            ie.in_valid = 1'b1; ie.in_data = d;
            beats.push_back($signed(d));
            step(1);
        end
        ie.in_valid = 1'b0;
        step(4);
        n_chk++; if (qe.size() != base + 4) $display("FAIL rst_mid_fresh_n got %0d want %0d", qe.size() - base, 4); else n_pass++;
        for (int k = 0; k < 4 && base + k < qe.size(); k++) begin
            exp_w = {16'(clamp(beats[2 * k + 1])), 16'(clamp(beats[2 * k]))};
            n_chk++; if (qe[base + k].a !== 11'(k) || qe[base + k].d !== exp_w)
                $display("FAIL rst_mid_w%0d got a=%0h d=%h want a=%0h d=%h", k, qe[base + k].a, qe[base + k].d, k, exp_w); else n_pass++;
        end
        n_chk++; if (dne.size() != 1) $display("FAIL rst_mid_done got %0d want 1", dne.size()); else n_pass++;
    endtask

    task automatic test_full_rate();
        int beats[$];
        logic [15:0] d;
        logic [31:0] exp_w;
        int t0;
        qd.delete(); dnd.delete();
        id.start = 1'b1; step(1); id.start = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 4096; i++) begin
            d = 16'($urandom);
            id.in_valid = 1'b1; id.in_data = d;
            beats.push_back($signed(d));
            step(1);
        end
        id.in_valid = 1'b0;
        step(5);
        n_chk++; if (qd.size() != 2048) $display("FAIL full_nwrites got %0d want 2048", qd.size()); else n_pass++;
        for (int k = 0; k < 2048 && k < qd.size(); k++) begin
            exp_w = {16'(beats[2 * k + 1]), 16'(beats[2 * k])};
            n_chk++; if (qd[k].a !== 11'(k) || qd[k].d !== exp_w || qd[k].c != t0 + 2 * k + 2)
                $display("FAIL full_w%0d got a=%0h d=%h c=%0d want a=%0h d=%h c=%0d", k, qd[k].a, qd[k].d, qd[k].c, k, exp_w, t0 + 2 * k + 2); else n_pass++;
        end
        if (qd.size() > 0) begin
            n_chk++; if (qd[qd.size() - 1].a !== 11'h7FF) $display("FAIL full_last_addr got %0h want 7ff", qd[qd.size() - 1].a); else n_pass++;
        end
        n_chk++; if (dnd.size() != 1) $display("FAIL full_done got %0d want 1", dnd.size()); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        ia.start = 1'b0; ia.in_valid = 1'b0; ia.in_data = 16'h0000;
        ib.start = 1'b0; ib.in_valid = 1'b0; ib.in_data = 16'h0000;
        ic.start = 1'b0; ic.in_valid = 1'b0; ic.in_data = 16'h0000;
        id.start = 1'b0; id.in_valid = 1'b0; id.in_data = 16'h0000;
        ie.start = 1'b0; ie.in_valid = 1'b0; ie.in_data = 16'h0000;
        rst_n = 1'b0;
        step(3);
        test_reset();
        rst_n = 1'b1;
        step(2);
        test_basic();
        test_flags();
        test_saturate();
        test_gaps();
        test_reset_midrun();
        test_full_rate();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
